vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480@60 VGA sync/blanking generator with 1-bit RGB pixel
//            output. Define VGA_TEST_PATTERN_EN for 8 colour bars instead of
//            the COLOR solid fill.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] color,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic       red,
    output logic       green,
    output logic       blue
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
    localparam logic [9:0] c_h_act    = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_act    = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_start = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_end   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_vs_start = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_end   = 10'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] c_bar_w    = 10'(H_ACTIVE / 8);
`endif

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_active;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_frame_start;
    logic [2:0] r_rgb;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_active;
    logic [2:0] w_pix;

    assign w_h_last = (r_h == c_h_last);
    assign w_v_last = (r_v == c_v_last);
    assign w_active = (r_h < c_h_act) && (r_v < c_v_act);

`ifdef VGA_TEST_PATTERN_EN
    // Bar index only matters inside the visible area, where it is 0..7
    assign w_pix = 3'(r_h / c_bar_w);
`else
    assign w_pix = color;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (w_h_last) begin
            r_h <= 10'd0;
            r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    // Outputs describe the pre-edge counter state, so all are mutually aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_active      <= 1'b0;
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_start <= 1'b0;
            r_rgb         <= 3'b000;
        end else begin
            r_hsync       <= !((r_h >= c_hs_start) && (r_h < c_hs_end));
            r_vsync       <= !((r_v >= c_vs_start) && (r_v < c_vs_end));
            r_active      <= w_active;
            r_x           <= r_h;
            r_y           <= r_v;
            r_frame_start <= (r_h == 10'd0) && (r_v == 10'd0);
            r_rgb         <= w_active ? w_pix : 3'b000;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;
    assign red         = r_rgb[2];
    assign green       = r_rgb[1];
    assign blue        = r_rgb[0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Randomized check of vga_timing_gen (full-size and shrunk
//            instances) against an arithmetic pixel-position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;
    logic [2:0] color;

    logic       b_hs, b_vs, b_act, b_fs, b_r, b_g, b_b;
    logic [9:0] b_x, b_y;
    logic       s_hs, s_vs, s_act, s_fs, s_r, s_g, s_b;
    logic [9:0] s_x, s_y;

    int checks;
    int errors;
    int k;              // rising edges since reset release; 0 while in reset
    logic [2:0] col_edge;
    int last_fs;
    int run [3];
    bit inrun [3];
    bit prev [3];

    localparam int SH_TOT = 16 + 2 + 3 + 3;
    localparam int SV_TOT = 6 + 2 + 2 + 2;
    localparam int S_FRAME = SH_TOT * SV_TOT;

    vga_timing_gen u_big (
        .clk(clk), .rst_n(rst_n), .color(color),
        .hsync(b_hs), .vsync(b_vs), .active(b_act), .x(b_x), .y(b_y),
        .frame_start(b_fs), .red(b_r), .green(b_g), .blue(b_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .color(color),
        .hsync(s_hs), .vsync(s_vs), .active(s_act), .x(s_x), .y(s_y),
        .frame_start(s_fs), .red(s_r), .green(s_g), .blue(s_b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // {hsync, vsync, active, frame_start, rgb[2:0], x[9:0], y[9:0]}
    function automatic logic [26:0] model(input int kk, input int ha, input int hf,
                                          input int hs, input int hb, input int va,
                                          input int vf, input int vs, input int vb,
                                          input logic [2:0] c);
        int ht, vt, p, h, v;
        logic act;
        logic [2:0] pix;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (kk == 0) return {1'b1, 1'b1, 25'd0};
        p   = (kk - 1) % (ht * vt);
        h   = p % ht;
        v   = p / ht;
        act = (h < ha) && (v < va);
`ifdef VGA_TEST_PATTERN_EN
        pix = 3'(h / (ha / 8));
`else
        pix = c;
`endif
        return {!(h >= ha + hf && h < ha + hf + hs), !(v >= va + vf && v < va + vf + vs),
                act, (p == 0), act ? pix : 3'b000, 10'(h), 10'(v)};
    endfunction

    task automatic check_all();
        bit s [3];
        int exp_len [3];
        check("big", {5'd0, b_hs, b_vs, b_act, b_fs, b_r, b_g, b_b, b_x, b_y},
              {5'd0, model(k, 640, 16, 96, 48, 480, 10, 2, 33, col_edge)});
        check("small", {5'd0, s_hs, s_vs, s_act, s_fs, s_r, s_g, s_b, s_x, s_y},
              {5'd0, model(k, 16, 2, 3, 3, 6, 2, 2, 2, col_edge)});
        if (s_fs) begin
            if (last_fs > 0) check("fs_period", k - last_fs, S_FRAME);
            last_fs = k;
        end
        s[0] = !b_hs;  exp_len[0] = 96;
        s[1] = !s_vs;  exp_len[1] = 2 * SH_TOT;
        s[2] = b_act;  exp_len[2] = 640;
        for (int j = 0; j < 3; j++) begin
            if (s[j] && !prev[j]) begin
                inrun[j] = 1'b1;
                run[j] = 1;
            end else if (s[j]) begin
                run[j]++;
            end else if (prev[j] && inrun[j]) begin
                check(j == 0 ? "hs_low_len" : (j == 1 ? "vs_low_len" : "active_len"),
                      run[j], exp_len[j]);
                inrun[j] = 1'b0;
            end
            prev[j] = s[j];
        end
    endtask

    task automatic cycle(input bit rnd);
        col_edge = color;
        @(posedge clk);
        if (rst_n) k++;
        else k = 0;
        @(negedge clk);
        check_all();
        if (rnd && $urandom_range(0, 7) == 0) color = 3'($urandom);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #5 rst_n = 1'b0;
        k = 0;
        last_fs = 0;
        for (int j = 0; j < 3; j++) inrun[j] = 1'b0;
        #1 check_all();
        for (int i = 0; i < n; i++) cycle(1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        k = 0;
        last_fs = 0;
        col_edge = 3'b111;
        for (int j = 0; j < 3; j++) begin
            run[j] = 0;
            inrun[j] = 1'b0;
            prev[j] = 1'b0;
        end
        rst_n = 1'b0;
        color = 3'b111;
        repeat (3) @(negedge clk);
        check_all();

        // Directed fill: 101 up to X=100, then 010 for the rest of the line
        rst_n = 1'b1;
        color = 3'b101;
        for (int i = 0; i < 800; i++) begin
            cycle(1'b0);
            if (((k - 1) % 800) == 100) color = 3'b010;
        end
        for (int i = 0; i < 1000; i++) cycle(1'b1);

        // Reset in the middle of a shrunk-frame visible line
        while (((k - 1) % S_FRAME) != 3 * SH_TOT + 10) cycle(1'b1);
        do_reset(3);
        for (int i = 0; i < 700; i++) cycle(1'b1);

        for (int r = 0; r < 3; r++) begin
            do_reset($urandom_range(1, 4));
            for (int i = 0; i < $urandom_range(300, 700); i++) cycle(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
